// File: rtl/lcd_char_driver.sv
// HD44780 16x2 character LCD driver: power-up wait, init command sequence, then
// continuous refresh of both lines from an upstream character source.
module lcd_char_driver #(
    parameter int POWERUP_CYC  = 750000,
    parameter int SETUP_CYC    = 4,
    parameter int EN_HIGH_CYC  = 16,
    parameter int CMD_WAIT_CYC = 2000,
    parameter int CLR_WAIT_CYC = 82000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] char_in,
    output logic       char_ack,
    output logic       char_line,
    output logic [3:0] char_col,
    output logic       init_done,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic       lcd_on,
    output logic       lcd_blon
);

    typedef enum logic [1:0] {S_POWERUP, S_INIT, S_ADDR, S_CHAR} state_e;
    typedef enum logic [1:0] {P_SETUP, P_PULSE, P_WAIT} phase_e;

    localparam logic [23:0] PWR_M1   = 24'(POWERUP_CYC - 1);
    localparam logic [23:0] SETUP_M1 = 24'(SETUP_CYC - 1);
    localparam logic [23:0] EN_M1    = 24'(EN_HIGH_CYC - 1);
    localparam logic [23:0] CMD_M1   = 24'(CMD_WAIT_CYC - 1);
    localparam logic [23:0] CLR_M1   = 24'(CLR_WAIT_CYC - 1);

    state_e      state_q, state_d;
    phase_e      phase_q, phase_d;
    logic [23:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic        line_q, line_d;
    logic [3:0]  col_q, col_d;
    logic        init_flag_q, init_flag_d;

    logic        en_q, rs_q, init_done_q;
    logic [7:0]  data_q;

    logic [7:0]  op_byte;
    logic        op_rs;
    logic        op_start;
    logic [23:0] phase_lim;

    function automatic logic [7:0] init_cmd(input logic [2:0] i);
        case (i)
            3'd0, 3'd1, 3'd2: init_cmd = 8'h38;
            3'd3:             init_cmd = 8'h0C;
            3'd4:             init_cmd = 8'h01;
            default:          init_cmd = 8'h06;
        endcase
    endfunction

    always_comb begin
        op_byte = 8'h00;
        op_rs   = (state_q == S_CHAR);
        case (state_q)
            S_INIT:  op_byte = init_cmd(idx_q);
            S_ADDR:  op_byte = line_q ? 8'hC0 : 8'h80;
            S_CHAR:  op_byte = char_in;
            default: op_byte = 8'h00;
        endcase
        // Only the clear command (init index 4) needs the long settle time.
        case (phase_q)
            P_SETUP: phase_lim = SETUP_M1;
            P_PULSE: phase_lim = EN_M1;
            default: phase_lim = (state_q == S_INIT && idx_q == 3'd4) ? CLR_M1 : CMD_M1;
        endcase
    end

    assign op_start = (state_q != S_POWERUP) && (phase_q == P_SETUP) && (cnt_q == 24'd0);

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        cnt_d       = cnt_q + 24'd1;
        idx_d       = idx_q;
        line_d      = line_q;
        col_d       = col_q;
        init_flag_d = init_flag_q;
        if (state_q == S_POWERUP) begin
            if (cnt_q == PWR_M1) begin
                state_d = S_INIT;
                phase_d = P_SETUP;
                cnt_d   = 24'd0;
                idx_d   = 3'd0;
            end
        end else if (cnt_q == phase_lim) begin
            cnt_d = 24'd0;
            case (phase_q)
                P_SETUP: phase_d = P_PULSE;
                P_PULSE: phase_d = P_WAIT;
                default: begin
                    phase_d = P_SETUP;
                    case (state_q)
                        S_INIT: begin
                            if (idx_q == 3'd5) begin
                                init_flag_d = 1'b1;
                                state_d     = S_ADDR;
                            end else begin
                                idx_d = idx_q + 3'd1;
                            end
                        end
                        S_ADDR: begin
                            state_d = S_CHAR;
                            col_d   = 4'd0;
                        end
                        default: begin
                            if (col_q == 4'd15) begin
                                col_d   = 4'd0;
                                line_d  = ~line_q;
                                state_d = S_ADDR;
                            end else begin
                                col_d = col_q + 4'd1;
                            end
                        end
                    endcase
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_POWERUP;
            phase_q     <= P_SETUP;
            cnt_q       <= 24'd0;
            idx_q       <= 3'd0;
            line_q      <= 1'b0;
            col_q       <= 4'd0;
            init_flag_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            line_q      <= line_d;
            col_q       <= col_d;
            init_flag_q <= init_flag_d;
        end
    end

    // Bus pins are registered one cycle behind the sequencer so they are glitch-free;
    // data and RS load once per op and hold until the next op's first SETUP cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_q        <= 1'b0;
            rs_q        <= 1'b0;
            data_q      <= 8'h00;
            init_done_q <= 1'b0;
        end else begin
            en_q        <= (state_q != S_POWERUP) && (phase_q == P_PULSE);
            init_done_q <= init_flag_q;
            if (op_start) begin
                data_q <= op_byte;
                rs_q   <= op_rs;
            end
        end
    end

    assign char_ack  = (state_q == S_CHAR) && (phase_q == P_SETUP) && (cnt_q == 24'd0);
    assign char_line = line_q;
    assign char_col  = col_q;
    assign init_done = init_done_q;
    assign lcd_data  = data_q;
    assign lcd_rs    = rs_q;
    assign lcd_rw    = 1'b0;
    assign lcd_en    = en_q;
    assign lcd_on    = rst;
    assign lcd_blon  = rst;

endmodule

// File: tb/tb_lcd_char_driver.sv
// Bench for lcd_char_driver with short timing parameters; bus ops are checked
// against an expected-byte queue on every falling edge of lcd_en.
module tb_lcd_char_driver;

    logic       clk;
    logic       rst;
    logic [7:0] char_in;
    logic       char_ack;
    logic       char_line;
    logic [3:0] char_col;
    logic       init_done;
    logic [7:0] lcd_data;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;
    logic       lcd_on;
    logic       lcd_blon;

    lcd_char_driver #(
        .POWERUP_CYC (10),
        .SETUP_CYC   (2),
        .EN_HIGH_CYC (3),
        .CMD_WAIT_CYC(5),
        .CLR_WAIT_CYC(20)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .char_in  (char_in),
        .char_ack (char_ack),
        .char_line(char_line),
        .char_col (char_col),
        .init_done(init_done),
        .lcd_data (lcd_data),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .lcd_en   (lcd_en),
        .lcd_on   (lcd_on),
        .lcd_blon (lcd_blon)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int         total;
    int         bad;
    logic [7:0] exp_q[$];
    int         sb_mode;     // 0 off, 1 every op, 2 character ops pushed on char_ack
    logic       rand_mode;
    logic       prev_en;
    logic       prev_rs;
    logic [7:0] prev_data;
    int         en_run;
    logic [7:0] pulse_byte;
    logic       rose;
    logic       ack_pend;
    logic [7:0] ack_val;
    int         ack_cnt;

    task automatic clear_tracking();
        prev_en  = 1'b0;
        prev_rs  = 1'b0;
        prev_data = 8'h00;
        en_run   = 0;
        ack_pend = 1'b0;
        exp_q.delete();
    endtask

    // One clock: sample at the falling edge, run bus invariants and the scoreboard,
    // then drive the next char_in.
    task automatic tick();
        logic [7:0] e;
        @(negedge clk);
        rose = 1'b0;
        total++;
        if (lcd_rw !== 1'b0) begin
            bad++;
            $display("FAIL rw_tied: got %b need 0", lcd_rw);
        end
        total++;
        if (lcd_on !== rst || lcd_blon !== rst) begin
            bad++;
            $display("FAIL power_pins: on=%b blon=%b need %b", lcd_on, lcd_blon, rst);
        end
        if (prev_en && lcd_en) begin
            total++;
            if (lcd_data !== prev_data || lcd_rs !== prev_rs) begin
                bad++;
                $display("FAIL bus_hold: data %h rs %b changed from %h %b while en high",
                         lcd_data, lcd_rs, prev_data, prev_rs);
            end
        end
        if (lcd_en) en_run++;
        if (!prev_en && lcd_en) begin
            rose = 1'b1;
            pulse_byte = lcd_data;
        end
        if (prev_en && !lcd_en) begin
            total++;
            if (en_run != 3) begin
                bad++;
                $display("FAIL en_width: got %0d need 3", en_run);
            end
            en_run = 0;
            if (sb_mode == 1 || (sb_mode == 2 && prev_rs)) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_empty: got byte %h with nothing expected", pulse_byte);
                end else begin
                    e = exp_q.pop_front();
                    if (pulse_byte !== e) begin
                        bad++;
                        $display("FAIL sb_byte: got %h need %h", pulse_byte, e);
                    end
                end
            end
        end
        if (ack_pend) begin
            total++;
            if (lcd_data !== ack_val || lcd_rs !== 1'b1 || lcd_en !== 1'b0) begin
                bad++;
                $display("FAIL ack_latch: got data %h rs %b en %b need %h 1 0",
                         lcd_data, lcd_rs, lcd_en, ack_val);
            end
            ack_pend = 1'b0;
        end
        prev_en   = lcd_en;
        prev_rs   = lcd_rs;
        prev_data = lcd_data;
        if (rand_mode) char_in = 8'($urandom_range(0, 255));
        else char_in = 8'(8'h41 + {4'b0, char_col} + (char_line ? 8'd16 : 8'd0));
        if (char_ack === 1'b1) begin
            ack_cnt++;
            ack_pend = 1'b1;
            ack_val  = char_in;
            if (sb_mode == 2) exp_q.push_back(char_in);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        total++;
        if ({lcd_en, lcd_rs, lcd_rw, lcd_data, char_ack, char_line, char_col, init_done,
             lcd_on, lcd_blon} !== 21'd0) begin
            bad++;
            $display("FAIL reset_values: en=%b rs=%b rw=%b data=%h ack=%b line=%b col=%0d done=%b on=%b blon=%b need all 0",
                     lcd_en, lcd_rs, lcd_rw, lcd_data, char_ack, char_line, char_col,
                     init_done, lcd_on, lcd_blon);
        end
    endtask

    // Caller releases rst just after a falling edge; tick t then follows rising edge t.
    task automatic test_powerup();
        int         s[6];
        logic [7:0] b[6];
        logic       exp_en;
        logic [7:0] exp_d;
        s = '{11, 21, 31, 41, 51, 76};
        b = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
        sb_mode = 1;
        for (int i = 0; i < 6; i++) exp_q.push_back(b[i]);
        for (int t = 1; t <= 86; t++) begin
            tick();
            exp_en = 1'b0;
            exp_d  = 8'h00;
            for (int i = 0; i < 6; i++) begin
                if (t >= s[i]) exp_d = b[i];
                if (t >= s[i] + 2 && t <= s[i] + 4) exp_en = 1'b1;
            end
            if (t >= 86) exp_d = 8'h80;
            total++;
            if (lcd_en !== exp_en || lcd_data !== exp_d || lcd_rs !== 1'b0) begin
                bad++;
                $display("FAIL init_timing edge %0d: got en %b data %h rs %b need %b %h 0",
                         t, lcd_en, lcd_data, lcd_rs, exp_en, exp_d);
            end
            total++;
            if (init_done !== (t >= 86)) begin
                bad++;
                $display("FAIL init_done edge %0d: got %b need %b", t, init_done, t >= 86);
            end
            total++;
            if (char_ack !== 1'b0 || char_line !== 1'b0 || char_col !== 4'd0) begin
                bad++;
                $display("FAIL init_idle edge %0d: got ack %b line %b col %0d need 0 0 0",
                         t, char_ack, char_line, char_col);
            end
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL init_ops: got %0d init bytes never seen need 0", exp_q.size());
        end
    endtask

    task automatic test_frame();
        sb_mode   = 1;
        rand_mode = 1'b0;
        exp_q.push_back(8'h80);
        for (int i = 0; i < 16; i++) exp_q.push_back(8'(8'h41 + i));
        exp_q.push_back(8'hC0);
        for (int i = 0; i < 16; i++) exp_q.push_back(8'(8'h51 + i));
        exp_q.push_back(8'h80);
        ack_cnt = 0;
        for (int i = 0; i < 340; i++) tick();
        total++;
        if (ack_cnt != 32) begin
            bad++;
            $display("FAIL frame_acks: got %0d need 32", ack_cnt);
        end
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL frame_ops: got %0d bytes outstanding need 0", exp_q.size());
        end
    endtask

    task automatic test_random_char();
        sb_mode   = 2;
        rand_mode = 1'b1;
        ack_cnt   = 0;
        for (int i = 0; i < 250; i++) tick();
        total++;
        if (ack_cnt < 20) begin
            bad++;
            $display("FAIL random_acks: got %0d need at least 20", ack_cnt);
        end
    endtask

    task automatic test_reset_mid_pulse();
        int  n;
        bit  found;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            tick();
            if (rose && !lcd_rs) found = 1'b1;
        end
        n = 0;
        for (int i = 0; i < 200 && found && n < 5; i++) begin
            tick();
            if (rose && lcd_rs) n++;
        end
        total++;
        if (n != 5) begin
            bad++;
            $display("FAIL find_5th_char: got %0d character pulses need 5", n);
        end
        total++;
        if (lcd_en !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_en: got %b need 1", lcd_en);
        end
        #2 rst = 1'b0;
        #1;
        total++;
        if ({lcd_en, lcd_rs, lcd_rw, lcd_data, char_ack, char_line, char_col, init_done,
             lcd_on, lcd_blon} !== 21'd0) begin
            bad++;
            $display("FAIL async_reset: en=%b rs=%b data=%h ack=%b line=%b col=%0d done=%b on=%b need all 0",
                     lcd_en, lcd_rs, lcd_data, char_ack, char_line, char_col, init_done, lcd_on);
        end
        clear_tracking();
        rand_mode = 1'b0;
        sb_mode   = 0;
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b1;
        test_powerup();
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        sb_mode   = 0;
        rand_mode = 1'b0;
        char_in   = 8'h00;
        rose      = 1'b0;
        ack_cnt   = 0;
        ack_val   = 8'h00;
        pulse_byte = 8'h00;
        clear_tracking();
        test_reset();
        rst = 1'b1;
        test_powerup();
        test_frame();
        test_random_char();
        test_reset_mid_pulse();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
